// File: rtl/turn_game_pkg.sv
// Shared constants, the player-number type and a priority helper for the
// six-player counting game.
package turn_game_pkg;

  localparam int NUM_PLAYERS        = 6;
  localparam int PLAYER_W           = 3;
  localparam int TOTAL_W            = 6;
  localparam int LOSE_TOTAL_DEFAULT = 31;
  localparam int MAX_MOVE_DEFAULT   = 5;

  typedef logic [PLAYER_W-1:0] player_t;

  // Lowest-numbered player (1-based) whose bit is set, or 0 when none is set.
  function automatic player_t lowest_player(input logic [NUM_PLAYERS-1:0] v);
    player_t r;
    r = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (v[i]) r = player_t'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/turn_game_btn_edge_sync.sv
// Two-flop synchronizer for one asynchronous button with a single-cycle
// rising-edge pulse. After reset the pulse stays disarmed until the
// synchronized button has been seen low, so a button held through reset
// release does not count as a press.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_async,
  output logic pulse
);

  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       armed_q, armed_d;
  logic [1:0] fill_q, fill_d;

  // Next values: shift the button through the chain, track when the chain
  // holds post-reset samples, and arm once the button is seen released.
  always_comb begin
    meta_d  = btn_async;
    sync_d  = meta_q;
    prev_d  = sync_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & ~sync_q);
  end

  // Synchronizer, edge and arming registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      fill_q  <= fill_d;
    end
  end

  assign pulse = sync_q & ~prev_q & armed_q;

endmodule

// File: rtl/turn_game.sv
// Six-player turn-based counting game core: detects button presses, checks
// turn order and move legality, accumulates the running total and latches
// the first loser until reset.
module turn_game
  import turn_game_pkg::*;
#(
  parameter int LOSE_TOTAL = LOSE_TOTAL_DEFAULT,
  parameter int MAX_MOVE   = MAX_MOVE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PLAYER_W-1:0]    player1,
  input  logic [PLAYER_W-1:0]    player2,
  input  logic [PLAYER_W-1:0]    player3,
  input  logic [PLAYER_W-1:0]    player4,
  input  logic [PLAYER_W-1:0]    player5,
  input  logic [PLAYER_W-1:0]    player6,
  input  logic [NUM_PLAYERS-1:0] player_clk,
  output logic [PLAYER_W-1:0]    out,
  output logic [PLAYER_W:0]      state_out
);

  logic [NUM_PLAYERS-1:0] press;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_btn
    btn_edge_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .btn_async (player_clk[g]),
      .pulse     (press[g])
    );
  end

  player_t                turn_q, turn_d;
  logic [TOTAL_W-1:0]     total_q, total_d;
  logic                   lost_q, lost_d;
  player_t                loser_q, loser_d;
  logic [PLAYER_W-1:0]    out_q, out_d;
  logic [PLAYER_W:0]      state_out_q, state_out_d;

  logic [NUM_PLAYERS-1:0] turn_mask;
  logic [NUM_PLAYERS-1:0] off_turn;
  logic [PLAYER_W-1:0]    move;
  logic                   move_legal;
  logic [TOTAL_W-1:0]     sum;

  // Select the turn player's move and derive the off-turn press set.
  always_comb begin
    turn_mask = NUM_PLAYERS'(1) << (turn_q - 3'd1);
    off_turn  = press & ~turn_mask;
    unique case (turn_q)
      3'd1:    move = player1;
      3'd2:    move = player2;
      3'd3:    move = player3;
      3'd4:    move = player4;
      3'd5:    move = player5;
      3'd6:    move = player6;
      default: move = '0;
    endcase
    move_legal = (move != '0) && (move <= PLAYER_W'(MAX_MOVE));
    sum        = total_q + TOTAL_W'(move);
  end

  // Game evaluation: off-turn presses beat the turn player's press, then the
  // move value and the running total decide between a loss and a new turn.
  always_comb begin
    turn_d  = turn_q;
    total_d = total_q;
    lost_d  = lost_q;
    loser_d = loser_q;
    if (!lost_q && (press != '0)) begin
      if (off_turn != '0) begin
        lost_d  = 1'b1;
        loser_d = lowest_player(off_turn);
      end else if (!move_legal) begin
        lost_d  = 1'b1;
        loser_d = turn_q;
      end else if (sum >= TOTAL_W'(LOSE_TOTAL)) begin
        total_d = sum;
        lost_d  = 1'b1;
        loser_d = turn_q;
      end else begin
        total_d = sum;
        turn_d  = (turn_q == player_t'(NUM_PLAYERS)) ? player_t'(1)
                                                     : turn_q + 3'd1;
      end
    end
  end

  // Output values are computed from the next state so they change together.
  always_comb begin
    out_d       = lost_d ? loser_d : '0;
    state_out_d = lost_d ? {1'b1, loser_d} : {1'b0, turn_d};
  end

  // Game state and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      turn_q      <= player_t'(1);
      total_q     <= '0;
      lost_q      <= 1'b0;
      loser_q     <= '0;
      out_q       <= '0;
      state_out_q <= 4'b0001;
    end else begin
      turn_q      <= turn_d;
      total_q     <= total_d;
      lost_q      <= lost_d;
      loser_q     <= loser_d;
      out_q       <= out_d;
      state_out_q <= state_out_d;
    end
  end

  assign out       = out_q;
  assign state_out = state_out_q;

endmodule

// File: tb/tb_turn_game.sv
// Directed self-checking bench for turn_game.
module tb_turn_game;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] pv [6];
  logic [5:0] player_clk = '0;
  logic [2:0] out;
  logic [3:0] state_out;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  turn_game dut (
    .clk        (clk),
    .rst        (rst),
    .player1    (pv[0]),
    .player2    (pv[1]),
    .player3    (pv[2]),
    .player4    (pv[3]),
    .player5    (pv[4]),
    .player6    (pv[5]),
    .player_clk (player_clk),
    .out        (out),
    .state_out  (state_out)
  );

  // Press the buttons in mask together, hold through the latency, release.
  task automatic applyStimulus(input logic [5:0] mask);
    @(negedge clk);
    player_clk = mask;
    repeat (4) @(negedge clk);
    player_clk = '0;
    repeat (2) @(negedge clk);
  endtask

  // Set one player's move value and press that player's button.
  task automatic playMove(input int p, input logic [2:0] v);
    pv[p-1] = v;
    applyStimulus(6'b1 << (p - 1));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] exp_state,
                             input logic [2:0] exp_out);
    checks++;
    assert (state_out === exp_state && out === exp_out) passed++;
    else $error("[TB] FAIL %s: state_out=%b out=%b, expected state_out=%b out=%b",
                tag, state_out, out, exp_state, exp_out);
  endtask

  task automatic checkTotal(input string tag, input logic [5:0] exp_total);
    checks++;
    assert (dut.total_q === exp_total) passed++;
    else $error("[TB] FAIL %s: total=%0d, expected %0d", tag, dut.total_q, exp_total);
  endtask

  logic [2:0] seq [10] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd1, 3'd2, 3'd4, 3'd5, 3'd1, 3'd2};

  initial begin
    for (int i = 0; i < 6; i++) pv[i] = 3'd0;

    // Reset value while in reset and after release
    repeat (2) @(negedge clk);
    checkOutput("in_reset", 4'b0001, 3'b000);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("after_reset", 4'b0001, 3'b000);

    // Ten legal moves; turn advances 1..6 then wraps
    for (int n = 0; n < 10; n++) begin
      playMove((n % 6) + 1, seq[n]);
      checkOutput($sformatf("move%0d", n + 1), {1'b0, 3'((n + 1) % 6 + 1)}, 3'b000);
    end
    checkTotal("total27", 6'd27);

    // Off-turn press by player 3 while player 5 is up
    playMove(3, 3'd1);
    checkOutput("offturn_p3", 4'b1011, 3'b011);
    playMove(5, 3'd1);
    checkOutput("ignored_after_loss", 4'b1011, 3'b011);
    checkTotal("total_frozen", 6'd27);

    // Players 1 and 2 press in the same cycle
    doReset();
    checkOutput("reset2", 4'b0001, 3'b000);
    pv[0] = 3'd1;
    pv[1] = 3'd1;
    applyStimulus(6'b000011);
    checkOutput("simul_p1p2", 4'b1010, 3'b010);

    // Zero move is illegal
    doReset();
    playMove(1, 3'd0);
    checkOutput("move_zero", 4'b1001, 3'b001);

    // Move above MAX_MOVE is illegal
    doReset();
    playMove(1, 3'd6);
    checkOutput("move_six", 4'b1001, 3'b001);

    // Button held through reset release is not a press
    @(negedge clk);
    pv[0] = 3'd3;
    player_clk = 6'b000001;
    doReset();
    repeat (4) @(negedge clk);
    checkOutput("held_thru_reset", 4'b0001, 3'b000);
    player_clk = '0;
    repeat (3) @(negedge clk);
    playMove(1, 3'd3);
    checkOutput("press_after_release", 4'b0010, 3'b000);

    // Six fives reach 30, then a 1 reaches the losing total
    doReset();
    for (int p = 1; p <= 6; p++) playMove(p, 3'd5);
    checkOutput("total30_turn1", 4'b0001, 3'b000);
    checkTotal("total30", 6'd30);
    playMove(1, 3'd1);
    checkOutput("reach31", 4'b1001, 3'b001);
    checkTotal("total31", 6'd31);

    // Reset takes effect at the next edge
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset", 4'b0001, 3'b000);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
